fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Control FSM for the Fetch stage. Drives the Fetch block's NewPC, PCSelector and enable inputs.
//  Owns boot-up, branch redirects with front-end flush, hazard stalls, and halt/restart.
//  Sits between the execute/hazard/decode units and Fetch; Fetch keeps its own PC register and incrementer.
// PARAMETERS
//  PC_WIDTH     19  width of NewPC, branch_target and start_pc
//  BOOT_PC      0   PC loaded after reset
//  BOOT_CYCLES  2   idle cycles after reset before the first load (instruction memory settle); >=1
//  FLUSH_CYCLES 1   cycles flush stays high per redirect, LOAD cycle included; >=1
//  COUNT_WIDTH  16  width of the redirect performance counter
// PORTS
//  clock          in   1            single clock; all state updates on posedge
//  reset          in   1            synchronous, active-high
//  branch_taken   in   1            redirect request from execute
//  branch_target  in   PC_WIDTH     redirect PC; sampled when branch_taken=1
//  stall          in   1            hazard-unit stall request
//  halt           in   1            decode saw the halt opcode
//  start          in   1            restart request; honoured only in HALT
//  start_pc       in   PC_WIDTH     restart PC; sampled with start
//  NewPC          out  PC_WIDTH     PC value for Fetch; meaningful when PCSelector=1
//  PCSelector     out  1            1: Fetch loads NewPC; 0: Fetch uses PC+increment
//  enable         out  1            Fetch PC register update enable
//  flush          out  1            kills the IF/ID register contents
//  fetch_valid    out  1            fetched instruction is valid this cycle
//  state_o        out  3            current state encoding (debug)
//  redirect_count out  COUNT_WIDTH  number of branch redirects, saturating
// BEHAVIOUR
//  - States / encoding: BOOT=0, LOAD=1, FLUSH=2, RUN=3, STALL=4, HALT=5. Other codes go to BOOT.
//  - Outputs are a pure decode of the state register plus the NewPC register, so there is no input-to-output combinational path.
//    An input sampled at edge N changes the outputs after edge N.
//  - Reset (synchronous, highest priority, any state):
//      state=BOOT, boot counter=BOOT_CYCLES, NewPC=BOOT_PC, redirect_count=0
//      outputs: PCSelector=1, enable=0, flush=1, fetch_valid=0.
//    Reset mid-operation discards any pending redirect or flush.
//  - Per-state outputs (PCSelector/enable/flush/fetch_valid):
//      BOOT 1/0/1/0; LOAD 1/1/1/0; FLUSH 0/1/1/0; RUN 0/1/0/1; STALL 0/0/0/0; HALT 0/0/0/0.
//  - BOOT: counter decrements each cycle. At 0 the FSM goes to LOAD with NewPC=BOOT_PC.
//    All other inputs are ignored.
//  - Transition priority in LOAD, FLUSH, RUN and STALL: branch_taken > halt > stall > default.
//  - branch_taken=1 in LOAD/FLUSH/RUN/STALL:
//      next state LOAD, NewPC<=branch_target, redirect_count+1 saturating at all-ones.
//    Back-to-back branches re-enter LOAD each cycle, and the newest target wins.
//  - LOAD lasts exactly 1 cycle. Next state is FLUSH (for FLUSH_CYCLES-1 cycles) when FLUSH_CYCLES>1, else RUN.
//  - halt and stall are ignored in LOAD and FLUSH, because the instruction is on a wrong or stale path.
//  - RUN: halt -> HALT; stall -> STALL; otherwise stay in RUN.
//  - STALL: stays while stall=1. On stall=0 it returns to RUN. halt has priority over stall.
//  - HALT: exited only by start=1, which goes to LOAD with NewPC<=start_pc.
//    branch_taken, stall and halt are ignored in HALT. start outside HALT is ignored.
//  - A halt and a branch in the same cycle: branch wins.
//  - The flush counter and boot counter are sized by $clog2 of their parameter+1. They must not wrap.
// STRUCTURE
//  - fetch_pkg:
//      typedef enum logic [2:0] fetch_state_e {BOOT, LOAD, FLUSH, RUN, STALL, HALT}
//      localparams PC_WIDTH=19 and INSTRUCTION_WIDTH=32, shared with Fetch.
//  - One sub-module, sat_counter #(WIDTH): increment enable, synchronous clear, saturates at all-ones.
//    It implements redirect_count.
//  - The rest is one always_ff for state, counters and NewPC, plus one always_comb for next-state logic and output decode.
// TESTING
//  1. Reset for 2 cycles, then release:
//     BOOT for 2 cycles (enable=0, flush=1), then 1 cycle of LOAD (NewPC=0, PCSelector=1, enable=1),
//     then RUN (PCSelector=0, enable=1, fetch_valid=1).
//  2. In RUN, pulse branch_taken=1 for 1 cycle with branch_target=19'h2:
//     next cycle LOAD with NewPC=2, PCSelector=1, flush=1, redirect_count=1; then RUN.
//     With FLUSH_CYCLES=3: LOAD, then 2 cycles of FLUSH, then RUN.
//  3. In RUN, hold stall=1 for 3 cycles: enable=0 for exactly 3 cycles, starting 1 cycle later, then RUN.
//     Stall and branch_taken asserted together -> LOAD.
//  4. In RUN, assert halt: HALT with enable=0. Then branch_taken=1 -> still HALT.
//     Then start=1 with start_pc=19'h40 -> LOAD with NewPC=19'h40, then RUN.
//  5. Assert reset during FLUSH (FLUSH_CYCLES=3): the next cycle is BOOT, redirect_count=0, flush=1, enable=0.
//  6. With COUNT_WIDTH=4, issue 20 branches: redirect_count reads 15 and stays at 15.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch-stage shared definitions.
//   fetch_state_e      : sequencer state encoding (also exported on state_o)
//   PC_WIDTH           : program counter width shared with the Fetch block
//   INSTRUCTION_WIDTH  : instruction word width shared with the Fetch block
package fetch_pkg;

    localparam int PC_WIDTH          = 19;
    localparam int INSTRUCTION_WIDTH = 32;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        STALL = 3'd4,
        HALT  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter.
//   clock : posedge clock
//   clear : synchronous clear to zero (wins over inc)
//   inc   : increment by one; held at all-ones once reached
//   count : current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: boot sequencing, branch redirect with front-end
// flush, hazard stalls and halt/restart. Fetch owns the PC register; this
// block only tells it when to load NewPC and when to advance.
//   clock, reset          : posedge clock, synchronous active-high reset
//   branch_taken/_target  : redirect request from execute
//   stall                 : hazard-unit stall request
//   halt                  : decode saw the halt opcode
//   start/start_pc        : restart request, honoured only in HALT
//   NewPC, PCSelector     : load value / load select for Fetch's PC
//   enable                : Fetch PC register update enable
//   flush                 : kills IF/ID contents
//   fetch_valid           : fetched instruction is valid
//   state_o               : current state (debug)
//   redirect_count        : saturating count of taken redirects
// All outputs decode registered state only, so no input reaches an output
// combinationally.
module fetch_sequencer #(
    parameter int          PC_WIDTH     = 19,
    parameter int unsigned BOOT_PC      = 0,
    parameter int          BOOT_CYCLES  = 2,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   stall,
    input  logic                   halt,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_pc,
    output logic [PC_WIDTH-1:0]    NewPC,
    output logic                   PCSelector,
    output logic                   enable,
    output logic                   flush,
    output logic                   fetch_valid,
    output logic [2:0]             state_o,
    output logic [COUNT_WIDTH-1:0] redirect_count
);

    import fetch_pkg::*;

    // Sized to hold the parameter value itself so neither counter can wrap.
    localparam int BOOT_W  = $clog2(BOOT_CYCLES + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    fetch_state_e        state, state_d;
    logic [BOOT_W-1:0]   boot_cnt;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [PC_WIDTH-1:0] new_pc;
    logic                redirect;   // branch accepted this cycle
    logic                restart;    // start accepted this cycle

    // ------------------------------------------------------------------
    // State, counters and NewPC register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= BOOT;
            boot_cnt  <= BOOT_W'(BOOT_CYCLES);
            flush_cnt <= '0;
            new_pc    <= PC_WIDTH'(BOOT_PC);
        end else begin
            state <= state_d;

            if (state == BOOT) begin
                if (boot_cnt != '0) boot_cnt <= boot_cnt - 1'b1;
                if (state_d == LOAD) new_pc <= PC_WIDTH'(BOOT_PC);
            end else if (state_d == BOOT) begin
                // recovery from an illegal code: re-arm the boot delay
                boot_cnt <= BOOT_W'(BOOT_CYCLES);
            end

            if (redirect)     new_pc <= branch_target;
            else if (restart) new_pc <= start_pc;

            // LOAD counts as the first flush cycle; FLUSH covers the rest.
            if (state == LOAD && state_d == FLUSH) begin
                flush_cnt <= FLUSH_W'(FLUSH_CYCLES - 1);
            end else if (state == FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state;
        redirect = 1'b0;
        restart  = 1'b0;
        case (state)
            BOOT: begin
                // leave on the cycle the counter reaches zero, giving
                // exactly BOOT_CYCLES cycles in BOOT
                if (boot_cnt <= BOOT_W'(1)) state_d = LOAD;
            end
            LOAD: begin
                if (branch_taken) begin
                    redirect = 1'b1;
                    state_d  = LOAD;
                end else if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // halt/stall belong to a stale instruction here
                if (branch_taken) begin
                    redirect = 1'b1;
                    state_d  = LOAD;
                end else if (flush_cnt <= FLUSH_W'(1)) begin
                    state_d = RUN;
                end
            end
            RUN, STALL: begin
                if (branch_taken) begin
                    redirect = 1'b1;
                    state_d  = LOAD;
                end else if (halt) begin
                    state_d = HALT;
                end else if (stall) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                if (start) begin
                    restart = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        PCSelector  = 1'b0;
        enable      = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        case (state)
            BOOT: begin
                PCSelector = 1'b1;
                flush      = 1'b1;
            end
            LOAD: begin
                PCSelector = 1'b1;
                enable     = 1'b1;
                flush      = 1'b1;
            end
            FLUSH: begin
                enable = 1'b1;
                flush  = 1'b1;
            end
            RUN: begin
                enable      = 1'b1;
                fetch_valid = 1'b1;
            end
            default: ;  // STALL, HALT and illegal codes: everything low
        endcase
    end

    assign NewPC   = new_pc;
    assign state_o = state;

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_redirect_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (redirect),
        .count (redirect_count)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Two instances share the input
// stimulus: dut_a (FLUSH_CYCLES=1, 16-bit counter) and dut_b (FLUSH_CYCLES=3,
// 4-bit counter); the idle one is held in reset. The driver pushes the
// expected post-edge outputs for every cycle; a monitor pops and compares.
module tb_fetch_sequencer;

    import fetch_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset_a = 1'b1;
    logic                reset_b = 1'b1;
    logic                branch_taken = 1'b0;
    logic [18:0]         branch_target = '0;
    logic                stall = 1'b0;
    logic                halt = 1'b0;
    logic                start = 1'b0;
    logic [18:0]         start_pc = '0;

    logic [18:0] pc_a, pc_b;
    logic        sel_a, en_a, fl_a, fv_a, sel_b, en_b, fl_b, fv_b;
    logic [2:0]  st_a, st_b;
    logic [15:0] rc_a;
    logic [3:0]  rc_b;

    fetch_sequencer #(
        .PC_WIDTH(19), .BOOT_PC(0), .BOOT_CYCLES(2), .FLUSH_CYCLES(1), .COUNT_WIDTH(16)
    ) dut_a (
        .clock(clock), .reset(reset_a), .branch_taken(branch_taken),
        .branch_target(branch_target), .stall(stall), .halt(halt),
        .start(start), .start_pc(start_pc), .NewPC(pc_a), .PCSelector(sel_a),
        .enable(en_a), .flush(fl_a), .fetch_valid(fv_a), .state_o(st_a),
        .redirect_count(rc_a)
    );

    fetch_sequencer #(
        .PC_WIDTH(19), .BOOT_PC(0), .BOOT_CYCLES(2), .FLUSH_CYCLES(3), .COUNT_WIDTH(4)
    ) dut_b (
        .clock(clock), .reset(reset_b), .branch_taken(branch_taken),
        .branch_target(branch_target), .stall(stall), .halt(halt),
        .start(start), .start_pc(start_pc), .NewPC(pc_b), .PCSelector(sel_b),
        .enable(en_b), .flush(fl_b), .fetch_valid(fv_b), .state_o(st_b),
        .redirect_count(rc_b)
    );

    typedef struct {
        bit           which;   // 0: dut_a, 1: dut_b
        fetch_state_e st;
        logic [18:0]  pc;
        int           rc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc_no = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // {PCSelector, enable, flush, fetch_valid} for each state
    function automatic logic [3:0] out_of(fetch_state_e s);
        case (s)
            BOOT:    return 4'b1010;
            LOAD:    return 4'b1110;
            FLUSH:   return 4'b0110;
            RUN:     return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    // Monitor: one expectation per clock edge, sampled 1 time unit after it.
    always @(posedge clock) begin
        exp_t e;
        logic [3:0] got_o;
        #1;
        cyc_no++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.which) begin
                got_o = {sel_a, en_a, fl_a, fv_a};
                chk($sformatf("a.state c%0d", cyc_no), 32'(st_a), 32'(e.st));
                chk($sformatf("a.ctl c%0d", cyc_no), 32'(got_o), 32'(out_of(e.st)));
                chk($sformatf("a.NewPC c%0d", cyc_no), 32'(pc_a), 32'(e.pc));
                chk($sformatf("a.rcount c%0d", cyc_no), 32'(rc_a), 32'(e.rc));
            end else begin
                got_o = {sel_b, en_b, fl_b, fv_b};
                chk($sformatf("b.state c%0d", cyc_no), 32'(st_b), 32'(e.st));
                chk($sformatf("b.ctl c%0d", cyc_no), 32'(got_o), 32'(out_of(e.st)));
                chk($sformatf("b.NewPC c%0d", cyc_no), 32'(pc_b), 32'(e.pc));
                chk($sformatf("b.rcount c%0d", cyc_no), 32'(rc_b), 32'(e.rc));
            end
        end
    end

    // Push the expectation for the coming edge, then advance to next negedge.
    task automatic cyc(input bit which, input fetch_state_e st, input logic [18:0] pc, input int rc);
        exp_t e;
        e.which = which; e.st = st; e.pc = pc; e.rc = rc;
        sb.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        // ---------------- dut_a: FLUSH_CYCLES=1 ----------------
        cyc(0, BOOT, 0, 0); cyc(0, BOOT, 0, 0);             // reset held 2 cycles
        reset_a = 0;
        cyc(0, BOOT, 0, 0); cyc(0, LOAD, 0, 0); cyc(0, RUN, 0, 0); cyc(0, RUN, 0, 0);
        // single branch
        branch_taken = 1; branch_target = 19'h2; cyc(0, LOAD, 19'h2, 1);
        branch_taken = 0; cyc(0, RUN, 19'h2, 1);
        // back-to-back branches: newest target wins
        branch_taken = 1; branch_target = 19'h5; cyc(0, LOAD, 19'h5, 2);
        branch_target = 19'h7; cyc(0, LOAD, 19'h7, 3);
        branch_taken = 0; cyc(0, RUN, 19'h7, 3);
        // 3-cycle stall
        stall = 1; cyc(0, STALL, 19'h7, 3); cyc(0, STALL, 19'h7, 3); cyc(0, STALL, 19'h7, 3);
        stall = 0; cyc(0, RUN, 19'h7, 3);
        // stall + branch -> LOAD; stall ignored in LOAD
        stall = 1; cyc(0, STALL, 19'h7, 3);
        branch_taken = 1; branch_target = 19'h9; cyc(0, LOAD, 19'h9, 4);
        branch_taken = 0; cyc(0, RUN, 19'h9, 4);
        cyc(0, STALL, 19'h9, 4);
        stall = 0; cyc(0, RUN, 19'h9, 4);
        // halt ignored in LOAD, honoured in RUN
        branch_taken = 1; branch_target = 19'h10; cyc(0, LOAD, 19'h10, 5);
        branch_taken = 0; halt = 1; cyc(0, RUN, 19'h10, 5);
        cyc(0, HALT, 19'h10, 5);
        // branch and stall ignored in HALT
        halt = 0; branch_taken = 1; branch_target = 19'h20; stall = 1; cyc(0, HALT, 19'h10, 5);
        branch_taken = 0; stall = 0; cyc(0, HALT, 19'h10, 5);
        // restart
        start = 1; start_pc = 19'h40; cyc(0, LOAD, 19'h40, 5);
        cyc(0, RUN, 19'h40, 5);                               // start outside HALT ignored
        start = 0; cyc(0, RUN, 19'h40, 5);
        // halt and branch together: branch wins
        halt = 1; branch_taken = 1; branch_target = 19'h30; cyc(0, LOAD, 19'h30, 6);
        halt = 0; branch_taken = 0; cyc(0, RUN, 19'h30, 6);
        // halt beats stall in STALL
        stall = 1; cyc(0, STALL, 19'h30, 6);
        halt = 1; cyc(0, HALT, 19'h30, 6);
        halt = 0; stall = 0; start = 1; start_pc = 19'h44; cyc(0, LOAD, 19'h44, 6);
        start = 0; cyc(0, RUN, 19'h44, 6);
        // reset mid-run
        reset_a = 1; cyc(0, BOOT, 0, 0);
        reset_a = 0; cyc(0, BOOT, 0, 0); cyc(0, LOAD, 0, 0); cyc(0, RUN, 0, 0);

        // ---------------- dut_b: FLUSH_CYCLES=3, COUNT_WIDTH=4 ----------------
        reset_a = 1;
        cyc(1, BOOT, 0, 0); cyc(1, BOOT, 0, 0);
        reset_b = 0;
        cyc(1, BOOT, 0, 0); cyc(1, LOAD, 0, 0); cyc(1, FLUSH, 0, 0); cyc(1, FLUSH, 0, 0);
        cyc(1, RUN, 0, 0);
        branch_taken = 1; branch_target = 19'h2; cyc(1, LOAD, 19'h2, 1);
        branch_taken = 0; cyc(1, FLUSH, 19'h2, 1); cyc(1, FLUSH, 19'h2, 1); cyc(1, RUN, 19'h2, 1);
        // stall and halt ignored through LOAD/FLUSH
        branch_taken = 1; branch_target = 19'h3; cyc(1, LOAD, 19'h3, 2);
        branch_taken = 0; stall = 1; halt = 1; cyc(1, FLUSH, 19'h3, 2); cyc(1, FLUSH, 19'h3, 2);
        halt = 0; cyc(1, RUN, 19'h3, 2);
        stall = 0; cyc(1, RUN, 19'h3, 2);
        // branch during FLUSH re-enters LOAD
        branch_taken = 1; branch_target = 19'h4; cyc(1, LOAD, 19'h4, 3);
        branch_taken = 0; cyc(1, FLUSH, 19'h4, 3);
        branch_taken = 1; branch_target = 19'h6; cyc(1, LOAD, 19'h6, 4);
        branch_taken = 0; cyc(1, FLUSH, 19'h6, 4);
        // reset during FLUSH discards the pending flush
        reset_b = 1; cyc(1, BOOT, 0, 0);
        reset_b = 0; cyc(1, BOOT, 0, 0); cyc(1, LOAD, 0, 0); cyc(1, FLUSH, 0, 0);
        cyc(1, FLUSH, 0, 0); cyc(1, RUN, 0, 0);
        // 20 branches: counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            branch_taken = 1; branch_target = 19'(i + 100);
            cyc(1, LOAD, 19'(i + 100), (i + 1 > 15) ? 15 : i + 1);
        end
        branch_taken = 0;
        cyc(1, FLUSH, 19'd119, 15); cyc(1, FLUSH, 19'd119, 15); cyc(1, RUN, 19'd119, 15);

        @(negedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
